phb_int_sched: RTL and testbench

Interrupt scheduler feeding the PSL/step-counter/branch chip.
- Latches interval-timer overflow and samples bus request levels BR7..BR4.
- Arbitrates them against the current PSL IPL and drives the interrupt_h / timer-service inputs used by the microcode branch logic.
- Sequences the microcode interrupt-acknowledge: device grant, vector capture with timeout, and vector readout onto the W-bus using the active-low-wired (all-ones-idle) convention.

---
 rtl/phb_int_sched.sv | 146 ++++++++++++++
 tb/tb_phb_int_sched.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/phb_int_sched.sv
// rtl/phb_int_sched.sv - interrupt scheduler: timer/BR arbitration against IPL and microcode INT_ACK sequencing
module phb_int_sched #(
    parameter int unsigned   TMO_CYC = 15,
    parameter logic [7:0]    TIM_VEC = 8'h30
) (
    input  logic       mclk_l,
    input  logic       sac_reset_h,
    input  logic       d_clk_en_h,
    input  logic [3:0] br_rq_h,
    input  logic       tim_ov_h,
    input  logic [4:0] ipl_h,
    input  logic [4:0] misc_ctl_h,
    input  logic [2:0] gd_sam_h,
    input  logic       dev_ack_h,
    input  logic [7:0] dev_vec_h,
    output logic       interrupt_h,
    output logic       timserv_h,
    output logic [3:0] br_grant_h,
    output logic       int_busy_h,
    output logic [7:0] wbus_9_2_out_h
);

    typedef enum logic [1:0] {ST_IDLE, ST_GRANT, ST_VECRDY} state_t;

    localparam logic [7:0] TMO_LAST = 8'(TMO_CYC - 1);

    state_t     state_q;
    logic       tim_pend_q;
    logic [7:0] vec_q;
    logic [7:0] tmo_cnt_q;
    logic [3:0] grant_q;
    logic       interrupt_q;

    logic [4:0] win_lvl;
    logic [3:0] win_oh;
    logic       win_any;
    logic       win_tim;
    logic       qual;
    logic       int_ack;
    logic       rd_vec;
    logic       tim_clr;

    assign int_ack = (misc_ctl_h == 5'h1E);
    assign rd_vec  = (gd_sam_h == 3'h7);

    // Fixed priority: timer (0x18) above BR7..BR4 (0x17..0x14)
    always_comb begin
        win_lvl = 5'h00;
        win_oh  = 4'b0000;
        win_any = 1'b0;
        win_tim = 1'b0;
        if (tim_pend_q) begin
            win_lvl = 5'h18;
            win_any = 1'b1;
            win_tim = 1'b1;
        end else if (br_rq_h[3]) begin
            win_lvl = 5'h17;
            win_oh  = 4'b1000;
            win_any = 1'b1;
        end else if (br_rq_h[2]) begin
            win_lvl = 5'h16;
            win_oh  = 4'b0100;
            win_any = 1'b1;
        end else if (br_rq_h[1]) begin
            win_lvl = 5'h15;
            win_oh  = 4'b0010;
            win_any = 1'b1;
        end else if (br_rq_h[0]) begin
            win_lvl = 5'h14;
            win_oh  = 4'b0001;
            win_any = 1'b1;
        end
    end

    assign qual    = win_any && (win_lvl > ipl_h);
    assign tim_clr = (misc_ctl_h == 5'h1F) ||
                     ((state_q == ST_IDLE) && int_ack && qual && win_tim);

    always_ff @(posedge mclk_l) begin
        if (sac_reset_h) begin
            state_q     <= ST_IDLE;
            tim_pend_q  <= 1'b0;
            vec_q       <= 8'h00;
            tmo_cnt_q   <= 8'h00;
            grant_q     <= 4'b0000;
            interrupt_q <= 1'b0;
        end else if (d_clk_en_h) begin
            // A new overflow outranks a clear arriving in the same cycle
            tim_pend_q <= tim_ov_h | (tim_pend_q & ~tim_clr);
            case (state_q)
                ST_IDLE: begin
                    if (int_ack) begin
                        interrupt_q <= 1'b0;
                        if (qual && win_tim) begin
                            vec_q   <= TIM_VEC;
                            state_q <= ST_VECRDY;
                        end else if (qual) begin
                            grant_q   <= win_oh;
                            tmo_cnt_q <= 8'h00;
                            state_q   <= ST_GRANT;
                        end else begin
                            vec_q   <= 8'h00;
                            state_q <= ST_VECRDY;
                        end
                    end else begin
                        interrupt_q <= qual;
                    end
                end
                ST_GRANT: begin
                    interrupt_q <= 1'b0;
                    if (dev_ack_h) begin
                        vec_q   <= dev_vec_h;
                        grant_q <= 4'b0000;
                        state_q <= ST_VECRDY;
                    end else if (tmo_cnt_q == TMO_LAST) begin
                        vec_q   <= 8'h00;
                        grant_q <= 4'b0000;
                        state_q <= ST_VECRDY;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + 8'h01;
                    end
                end
                ST_VECRDY: begin
                    if (rd_vec) begin
                        state_q     <= ST_IDLE;
                        interrupt_q <= qual;
                    end else begin
                        interrupt_q <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    grant_q     <= 4'b0000;
                    interrupt_q <= 1'b0;
                end
            endcase
        end
    end

    assign interrupt_h    = interrupt_q;
    assign timserv_h      = tim_pend_q;
    assign br_grant_h     = grant_q;
    assign int_busy_h     = (state_q != ST_IDLE);
    assign wbus_9_2_out_h = ((state_q == ST_VECRDY) && rd_vec) ? vec_q : 8'hFF;

endmodule

// File: tb/tb_phb_int_sched.sv
// tb/tb_phb_int_sched.sv - directed self-checking bench for phb_int_sched
module tb_phb_int_sched;

    logic       mclk_l = 1'b0;
    logic       sac_reset_h = 1'b0;
    logic       d_clk_en_h = 1'b1;
    logic [3:0] br_rq_h = 4'b0000;
    logic       tim_ov_h = 1'b0;
    logic [4:0] ipl_h = 5'h00;
    logic [4:0] misc_ctl_h = 5'h00;
    logic [2:0] gd_sam_h = 3'h0;
    logic       dev_ack_h = 1'b0;
    logic [7:0] dev_vec_h = 8'h00;
    logic       interrupt_h;
    logic       timserv_h;
    logic [3:0] br_grant_h;
    logic       int_busy_h;
    logic [7:0] wbus_9_2_out_h;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];

    phb_int_sched #(.TMO_CYC(15), .TIM_VEC(8'h30)) dut (
        .mclk_l         (mclk_l),
        .sac_reset_h    (sac_reset_h),
        .d_clk_en_h     (d_clk_en_h),
        .br_rq_h        (br_rq_h),
        .tim_ov_h       (tim_ov_h),
        .ipl_h          (ipl_h),
        .misc_ctl_h     (misc_ctl_h),
        .gd_sam_h       (gd_sam_h),
        .dev_ack_h      (dev_ack_h),
        .dev_vec_h      (dev_vec_h),
        .interrupt_h    (interrupt_h),
        .timserv_h      (timserv_h),
        .br_grant_h     (br_grant_h),
        .int_busy_h     (int_busy_h),
        .wbus_9_2_out_h (wbus_9_2_out_h)
    );

    always #5 mclk_l = ~mclk_l;

    task automatic tick();
        @(posedge mclk_l);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic read_vec(input string tag);
        logic [7:0] e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s: observed empty scoreboard expected entry", tag);
        end else begin
            e = exp_q.pop_front();
            gd_sam_h = 3'h7;
            #1;
            chk(tag, {24'h0, wbus_9_2_out_h}, {24'h0, e});
            tick();
            gd_sam_h = 3'h0;
            chk({tag, "_idle"}, {31'h0, int_busy_h}, 32'h0);
        end
    endtask

    initial begin
        int en_cnt;
        int guard;

        // Reset with a simultaneous timer pulse
        sac_reset_h = 1'b1;
        tim_ov_h = 1'b1;
        tick();
        sac_reset_h = 1'b0;
        tim_ov_h = 1'b0;
        chk("rst_timserv", {31'h0, timserv_h}, 32'h0);
        chk("rst_int", {31'h0, interrupt_h}, 32'h0);
        chk("rst_grant", {28'h0, br_grant_h}, 32'h0);
        chk("rst_busy", {31'h0, int_busy_h}, 32'h0);
        chk("rst_wbus", {24'h0, wbus_9_2_out_h}, 32'hFF);

        // IPL qualification with one-cycle latency
        ipl_h = 5'h15;
        br_rq_h = 4'b0100;
        tick();
        chk("int_br6", {31'h0, interrupt_h}, 32'h1);
        ipl_h = 5'h16;
        tick();
        chk("int_masked", {31'h0, interrupt_h}, 32'h0);

        // Timer beats BR7
        br_rq_h = 4'b1000;
        ipl_h = 5'h00;
        tim_ov_h = 1'b1;
        tick();
        tim_ov_h = 1'b0;
        chk("tim_set", {31'h0, timserv_h}, 32'h1);
        misc_ctl_h = 5'h1E;
        exp_q.push_back(8'h30);
        tick();
        misc_ctl_h = 5'h00;
        chk("tim_busy", {31'h0, int_busy_h}, 32'h1);
        chk("tim_nogrant", {28'h0, br_grant_h}, 32'h0);
        chk("tim_clr", {31'h0, timserv_h}, 32'h0);
        chk("tim_int_off", {31'h0, interrupt_h}, 32'h0);
        read_vec("tim_vec");
        chk("br7_int", {31'h0, interrupt_h}, 32'h1);
        chk("wbus_idle", {24'h0, wbus_9_2_out_h}, 32'hFF);

        // READ_INT_VEC outside VECRDY drives all ones
        gd_sam_h = 3'h7;
        #1;
        chk("rd_idle", {24'h0, wbus_9_2_out_h}, 32'hFF);
        gd_sam_h = 3'h0;

        // BR4 grant with device ack after 3 cycles
        br_rq_h = 4'b0001;
        misc_ctl_h = 5'h1E;
        tick();
        misc_ctl_h = 5'h00;
        chk("br4_grant", {28'h0, br_grant_h}, 32'h1);
        br_rq_h = 4'b0000;
        tick();
        tick();
        chk("grant_held", {28'h0, br_grant_h}, 32'h1);
        dev_ack_h = 1'b1;
        dev_vec_h = 8'h2D;
        exp_q.push_back(8'h2D);
        tick();
        dev_ack_h = 1'b0;
        chk("grant_drop", {28'h0, br_grant_h}, 32'h0);
        read_vec("dev_vec");

        // Timeout with clock enable toggling
        br_rq_h = 4'b0010;
        misc_ctl_h = 5'h1E;
        tick();
        misc_ctl_h = 5'h00;
        br_rq_h = 4'b0000;
        chk("br5_grant", {28'h0, br_grant_h}, 32'h2);
        exp_q.push_back(8'h00);
        en_cnt = 0;
        guard = 0;
        while (br_grant_h != 4'b0000 && guard < 200) begin
            d_clk_en_h = (guard % 3) != 2;
            tick();
            if (d_clk_en_h) en_cnt++;
            guard++;
        end
        d_clk_en_h = 1'b1;
        chk("tmo_bound", {31'h0, guard < 200}, 32'h1);
        chk("tmo_count", en_cnt, 15);
        read_vec("tmo_vec");

        // Passive release when nothing qualifies
        ipl_h = 5'h1F;
        misc_ctl_h = 5'h1E;
        exp_q.push_back(8'h00);
        tick();
        misc_ctl_h = 5'h00;
        chk("pass_nogrant", {28'h0, br_grant_h}, 32'h0);
        read_vec("pass_vec");
        ipl_h = 5'h00;

        // Set wins over clear; disabled pulse is lost
        tim_ov_h = 1'b1;
        misc_ctl_h = 5'h1F;
        tick();
        tim_ov_h = 1'b0;
        chk("set_wins", {31'h0, timserv_h}, 32'h1);
        tick();
        misc_ctl_h = 5'h00;
        chk("clr_timserv", {31'h0, timserv_h}, 32'h0);
        d_clk_en_h = 1'b0;
        tim_ov_h = 1'b1;
        tick();
        tim_ov_h = 1'b0;
        d_clk_en_h = 1'b1;
        chk("ov_lost", {31'h0, timserv_h}, 32'h0);

        // Reset mid-grant
        br_rq_h = 4'b0001;
        misc_ctl_h = 5'h1E;
        tick();
        misc_ctl_h = 5'h00;
        chk("rg_grant", {28'h0, br_grant_h}, 32'h1);
        sac_reset_h = 1'b1;
        tick();
        sac_reset_h = 1'b0;
        chk("rg_drop", {28'h0, br_grant_h}, 32'h0);
        chk("rg_idle", {31'h0, int_busy_h}, 32'h0);

        chk("sb_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
